// File: rtl/ritc_align_pkg.sv
// Shared types and constants for the RITC bit-alignment block.
package ritc_align_pkg;

   localparam int unsigned WordW = 4;   // deserialized word width
   localparam int unsigned TapW  = 5;   // IDELAY tap width
   localparam int unsigned EyeW  = 6;   // eye width (0..32 taps)
   localparam int unsigned SlipW = 3;

   localparam logic [TapW-1:0]  TapLast  = '1;
   localparam logic [SlipW-1:0] MaxSlips = 3'd4;

   typedef enum logic [3:0] {
      StIdle,
      StLoad,
      StSettle,
      StCheck,
      StNext,
      StCenter,
      StCsettle,
      StSlipChk,
      StSlip,
      StSlipWait,
      StDone,
      StFail
   } state_e;

   // True when word equals any of the WordW rotations of pat.
   function automatic logic is_rotation(input logic [WordW-1:0] word,
                                        input logic [WordW-1:0] pat);
      logic [WordW-1:0] r;
      logic             hit;
      r   = pat;
      hit = 1'b0;
      for (int i = 0; i < WordW; i++) begin
         if (word == r) hit = 1'b1;
         r = {r[WordW-2:0], r[WordW-1]};
      end
      return hit;
   endfunction

endpackage

// File: rtl/ritc_bit_align_if.sv
// Control/status and data bundle between the alignment FSM and its user.
interface ritc_bit_align_if;

   logic                                   start_i;
   logic [ritc_align_pkg::WordW-1:0]       serdes_i;
   logic [ritc_align_pkg::TapW-1:0]        delay_o;
   logic                                   load_o;
   logic                                   bitslip_o;
   logic                                   busy_o;
   logic                                   done_o;
   logic                                   fail_o;
   logic [ritc_align_pkg::TapW-1:0]        eye_start_o;
   logic [ritc_align_pkg::EyeW-1:0]        eye_width_o;

   // Aligner side
   modport slave (
      input  start_i, serdes_i,
      output delay_o, load_o, bitslip_o, busy_o, done_o, fail_o, eye_start_o, eye_width_o
   );

   // Controller / data-path side
   modport master (
      output start_i, serdes_i,
      input  delay_o, load_o, bitslip_o, busy_o, done_o, fail_o, eye_start_o, eye_width_o
   );

endinterface

// File: rtl/ritc_align_pattern_match.sv
// Per-tap word checker: latches the first word, flags whether it is a training
// rotation, and remembers any later word that differs from it.
module ritc_align_pattern_match
   import ritc_align_pkg::*;
#(
   parameter logic [WordW-1:0] TRAIN_PATTERN = 4'b1100
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             first_i,
   input  logic             cmp_i,
   input  logic [WordW-1:0] serdes_i,
   output logic             good_o
);

   logic [WordW-1:0] first_q;
   logic             rot_q;
   logic             mism_q;

   // Capture reference word on first_i, accumulate mismatches on cmp_i.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         first_q <= '0;
         rot_q   <= 1'b0;
         mism_q  <= 1'b0;
      end else if (first_i) begin
         first_q <= serdes_i;
         rot_q   <= is_rotation(serdes_i, TRAIN_PATTERN);
         mism_q  <= 1'b0;
      end else if (cmp_i && (serdes_i != first_q)) begin
         mism_q  <= 1'b1;
      end
   end

   assign good_o = rot_q & ~mism_q;

endmodule

// File: rtl/ritc_bit_align.sv
// IDELAY eye scan followed by ISERDES bitslip word alignment.
module ritc_bit_align
   import ritc_align_pkg::*;
#(
   parameter logic [WordW-1:0] TRAIN_PATTERN = 4'b1100,
   parameter int unsigned      SETTLE_CYCLES = 8,
   parameter int unsigned      CHECK_CYCLES  = 64,
   parameter int unsigned      MIN_EYE       = 3,
   parameter int unsigned      SLIP_WAIT     = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   ritc_bit_align_if.slave   bus_io
);

   localparam int unsigned CntMax0 = (SETTLE_CYCLES > CHECK_CYCLES) ? SETTLE_CYCLES : CHECK_CYCLES;
   localparam int unsigned CntMax  = (CntMax0 > SLIP_WAIT) ? CntMax0 : SLIP_WAIT;
   localparam int unsigned CntW    = $clog2(CntMax + 1);

   localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);
   localparam logic [CntW-1:0] CheckLast  = CntW'(CHECK_CYCLES - 1);
   localparam logic [CntW-1:0] SlipLast   = CntW'(SLIP_WAIT - 1);
   localparam logic [EyeW-1:0] MinEye     = EyeW'(MIN_EYE);

   state_e           state_q;
   logic [TapW-1:0]  tap_q;
   logic [CntW-1:0]  cnt_q;
   logic [SlipW-1:0] slip_q;
   logic [TapW-1:0]  run_start_q, best_start_q;
   logic [EyeW-1:0]  run_len_q, best_len_q;
   logic [TapW-1:0]  delay_q;
   logic             load_q, bitslip_q, busy_q, done_q, fail_q;

   logic [TapW-1:0]  run_start_d, center_d;
   logic [EyeW-1:0]  run_len_d;
   logic             match_first, match_cmp, tap_good;

   assign match_first = (state_q == StCheck) && (cnt_q == '0);
   assign match_cmp   = (state_q == StCheck) && (cnt_q != '0);

   ritc_align_pattern_match #(
      .TRAIN_PATTERN (TRAIN_PATTERN)
   ) u_match (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .first_i  (match_first),
      .cmp_i    (match_cmp),
      .serdes_i (bus_io.serdes_i),
      .good_o   (tap_good)
   );

   // Run extension for a good tap and the eye centre tap.
   always_comb begin
      run_len_d   = run_len_q + 1'b1;
      run_start_d = (run_len_q == '0) ? tap_q : run_start_q;
      // start + width/2 never exceeds 31 since start + width <= 32
      center_d    = best_start_q + TapW'(best_len_q >> 1);
   end

   // Alignment FSM with its counters and registered outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         tap_q        <= '0;
         cnt_q        <= '0;
         slip_q       <= '0;
         run_start_q  <= '0;
         run_len_q    <= '0;
         best_start_q <= '0;
         best_len_q   <= '0;
         delay_q      <= '0;
         load_q       <= 1'b0;
         bitslip_q    <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         fail_q       <= 1'b0;
      end else begin
         load_q    <= 1'b0;
         bitslip_q <= 1'b0;
         case (state_q)
            StIdle, StDone, StFail: begin
               if (bus_io.start_i) begin
                  tap_q        <= '0;
                  delay_q      <= '0;
                  load_q       <= 1'b1;
                  cnt_q        <= '0;
                  slip_q       <= '0;
                  run_start_q  <= '0;
                  run_len_q    <= '0;
                  best_start_q <= '0;
                  best_len_q   <= '0;
                  busy_q       <= 1'b1;
                  done_q       <= 1'b0;
                  fail_q       <= 1'b0;
                  state_q      <= StLoad;
               end
            end
            StLoad: begin
               cnt_q   <= '0;
               state_q <= StSettle;
            end
            StSettle: begin
               if (cnt_q == SettleLast) begin
                  cnt_q   <= '0;
                  state_q <= StCheck;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StCheck: begin
               if (cnt_q == CheckLast) begin
                  cnt_q   <= '0;
                  state_q <= StNext;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StNext: begin
               // Best eye tracks the open run, so a run still open at tap 31 is covered.
               if (tap_good) begin
                  run_len_q   <= run_len_d;
                  run_start_q <= run_start_d;
                  if (run_len_d > best_len_q) begin
                     best_len_q   <= run_len_d;
                     best_start_q <= run_start_d;
                  end
               end else begin
                  run_len_q <= '0;
               end
               if (tap_q != TapLast) begin
                  tap_q   <= tap_q + 1'b1;
                  delay_q <= tap_q + 1'b1;
                  load_q  <= 1'b1;
                  state_q <= StLoad;
               end else begin
                  state_q <= StCenter;
               end
            end
            StCenter: begin
               if (best_len_q < MinEye) begin
                  fail_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= StFail;
               end else begin
                  tap_q   <= center_d;
                  delay_q <= center_d;
                  load_q  <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= StCsettle;
               end
            end
            StCsettle: begin
               if (cnt_q == SettleLast) begin
                  cnt_q   <= '0;
                  state_q <= StSlipChk;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StSlipChk: begin
               if (bus_io.serdes_i == TRAIN_PATTERN) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= StDone;
               end else if (slip_q < MaxSlips) begin
                  bitslip_q <= 1'b1;
                  state_q   <= StSlip;
               end else begin
                  fail_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= StFail;
               end
            end
            StSlip: begin
               slip_q  <= slip_q + 1'b1;
               cnt_q   <= '0;
               state_q <= StSlipWait;
            end
            StSlipWait: begin
               if (cnt_q == SlipLast) begin
                  cnt_q   <= '0;
                  state_q <= StSlipChk;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus_io.delay_o     = delay_q;
   assign bus_io.load_o      = load_q;
   assign bus_io.bitslip_o   = bitslip_q;
   assign bus_io.busy_o      = busy_q;
   assign bus_io.done_o      = done_q;
   assign bus_io.fail_o      = fail_q;
   assign bus_io.eye_start_o = best_start_q;
   assign bus_io.eye_width_o = best_len_q;

endmodule

// File: tb/tb_ritc_bit_align.sv
// Directed bench for ritc_bit_align: a behavioural data path returns a
// training rotation on "good" taps and a non-rotation word elsewhere.
module tb_ritc_bit_align;

   localparam logic [3:0] Train    = 4'b1100;
   localparam logic [3:0] BadWord  = 4'b1010;
   localparam int         SlipWait = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   ritc_bit_align_if bus ();

   ritc_bit_align #(
      .TRAIN_PATTERN (Train),
      .SETTLE_CYCLES (8),
      .CHECK_CYCLES  (64),
      .MIN_EYE       (3),
      .SLIP_WAIT     (SlipWait)
   ) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .bus_io (bus)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] good_mask = '0;
   int          rot0 = 0;
   bit          slip_stuck = 1'b0;
   int          slips = 0;
   int          cyc = 0;
   int          n_bitslip = 0, n_load = 0, n_overlap = 0;
   int          last_slip_cyc = -1, min_gap = 1000;
   bit          fin;

   function automatic logic [3:0] rotr(input logic [3:0] p, input int k);
      logic [7:0] d;
      d = {p, p};
      d = d >> k;
      return d[3:0];
   endfunction

   function automatic logic [31:0] span(input int lo, input int hi);
      logic [31:0] m;
      m = '0;
      for (int i = lo; i <= hi; i++) m[i] = 1'b1;
      return m;
   endfunction

   // Behavioural data path: eye set by good_mask, word phase by rot0 + slips.
   always_comb begin
      bus.serdes_i = good_mask[bus.delay_o] ? rotr(Train, (rot0 + slips) % 4) : BadWord;
   end

   // Strobe monitor on the falling edge.
   always @(negedge clk) begin
      cyc++;
      if (bus.load_o) n_load++;
      if (bus.load_o && bus.bitslip_o) n_overlap++;
      if (bus.bitslip_o) begin
         n_bitslip++;
         if (last_slip_cyc >= 0 && (cyc - last_slip_cyc) < min_gap) min_gap = cyc - last_slip_cyc;
         last_slip_cyc = cyc;
         if (!slip_stuck) slips++;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic run_scan(input logic [31:0] mask, input int r0, input bit stuck,
                           input bit mid_start, output bit finished);
      good_mask  = mask;
      rot0       = r0;
      slip_stuck = stuck;
      slips      = 0;
      @(negedge clk);
      n_load = 0; n_bitslip = 0; n_overlap = 0; last_slip_cyc = -1; min_gap = 1000;
      bus.start_i = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      finished = 1'b0;
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk);
         bus.start_i = (mid_start && i == 300);
         if (!bus.busy_o) begin
            finished = 1'b1;
            break;
         end
      end
      bus.start_i = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check_eq({tag, "_delay"}, 32'(bus.delay_o), 0);
      check_eq({tag, "_load"}, 32'(bus.load_o), 0);
      check_eq({tag, "_bitslip"}, 32'(bus.bitslip_o), 0);
      check_eq({tag, "_busy"}, 32'(bus.busy_o), 0);
      check_eq({tag, "_done"}, 32'(bus.done_o), 0);
      check_eq({tag, "_fail"}, 32'(bus.fail_o), 0);
      check_eq({tag, "_eye_start"}, 32'(bus.eye_start_o), 0);
      check_eq({tag, "_eye_width"}, 32'(bus.eye_width_o), 0);
   endtask

   task automatic check_result(input string tag, input bit exp_done, input int exp_start,
                               input int exp_width, input int exp_delay, input int exp_slips,
                               input int exp_loads);
      check_eq({tag, "_finished"}, 32'(fin), 1);
      check_eq({tag, "_done"}, 32'(bus.done_o), 32'(exp_done));
      check_eq({tag, "_fail"}, 32'(bus.fail_o), 32'(!exp_done));
      check_eq({tag, "_busy"}, 32'(bus.busy_o), 0);
      check_eq({tag, "_eye_start"}, 32'(bus.eye_start_o), exp_start);
      check_eq({tag, "_eye_width"}, 32'(bus.eye_width_o), exp_width);
      if (exp_delay >= 0) check_eq({tag, "_delay"}, 32'(bus.delay_o), exp_delay);
      check_eq({tag, "_bitslips"}, n_bitslip, exp_slips);
      check_eq({tag, "_loads"}, n_load, exp_loads);
      check_eq({tag, "_load_bitslip_overlap"}, n_overlap, 0);
   endtask

   initial begin
      bus.start_i = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;

      // Eye 10..20, unrotated data: centre 10 + 11/2 = 15
      run_scan(span(10, 20), 0, 1'b0, 1'b0, fin);
      check_result("eye10_20", 1'b1, 10, 11, 15, 0, 33);

      // Same scan with a stray start while busy
      run_scan(span(10, 20), 0, 1'b0, 1'b1, fin);
      check_result("busy_start", 1'b1, 10, 11, 15, 0, 33);

      // Two eyes, the wider later one wins: 20 + 5/2 = 22
      run_scan(span(2, 4) | span(20, 24), 0, 1'b0, 1'b0, fin);
      check_result("two_eyes", 1'b1, 20, 5, 22, 0, 33);

      // Run still open at tap 31: 26 + 6/2 = 29
      run_scan(span(26, 31), 0, 1'b0, 1'b0, fin);
      check_result("eye_top", 1'b1, 26, 6, 29, 0, 33);

      // Eye 5..9, data rotated by 2: two bitslips, centre 7
      run_scan(span(5, 9), 2, 1'b0, 1'b0, fin);
      check_result("rot2", 1'b1, 5, 5, 7, 2, 33);
      check_eq("rot2_slip_gap_ok", 32'(min_gap >= SlipWait + 1), 1);

      // Single good tap: eye too narrow, no centre load
      run_scan(span(7, 7), 0, 1'b0, 1'b0, fin);
      check_result("narrow", 1'b0, 7, 1, 31, 0, 32);

      // Rotation that never resolves: four slips then fail
      run_scan(span(10, 20), 1, 1'b1, 1'b0, fin);
      check_result("no_resolve", 1'b0, 10, 11, 15, 4, 33);

      // Reset during CHECK at tap 12
      good_mask = span(10, 20); rot0 = 0; slip_stuck = 1'b0; slips = 0;
      @(negedge clk);
      bus.start_i = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      fin = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (bus.load_o && bus.delay_o == 5'd12) begin
            fin = 1'b1;
            break;
         end
      end
      check_eq("mid_reset_reached_tap12", 32'(fin), 1);
      repeat (20) @(negedge clk);   // 1 load + 8 settle cycles, then inside CHECK
      check_eq("mid_reset_busy_before", 32'(bus.busy_o), 1);
      rst = 1'b1;
      @(negedge clk);
      check_zero("mid_reset");
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("post_reset_idle_busy", 32'(bus.busy_o), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ritc_bit_align.md
RITC_BIT_ALIGN -- requirements
Module: ritc_bit_align

Interface
REQ-001 Parameter TRAIN_PATTERN, default 4'b1100: expected training word on serdes_i after alignment.
REQ-002 Parameter SETTLE_CYCLES, default 8: wait after every IDELAY load before sampling.
REQ-003 Parameter CHECK_CYCLES, default 64: samples compared per tap.
REQ-004 Parameter MIN_EYE, default 3: minimum good-tap run accepted.
REQ-005 Parameter SLIP_WAIT, default 4: wait after each bitslip pulse.
REQ-006 clk_i  in  1  the DATACLK_DIV2 domain clock; one clock only.
REQ-007 rst_i  in  1  synchronous, active-high reset.
REQ-008 start_i  in  1  one-cycle request to begin alignment.
REQ-009 serdes_i  in  4  deserialized word from the bit data path, Q1 in bit 0.
REQ-010 delay_o  out  5  IDELAY tap value.
REQ-011 load_o  out  1  one-cycle IDELAY load strobe.
REQ-012 bitslip_o  out  1  one-cycle ISERDES bitslip strobe.
REQ-013 busy_o / done_o / fail_o  out  1 each  status; done_o and fail_o are sticky until the next start or reset.
REQ-014 eye_start_o  out  5, eye_width_o  out  6: first tap and length of the selected eye.

Function
REQ-015 States are IDLE, LOAD, SETTLE, CHECK, NEXT, CENTER, CSETTLE, SLIPCHK, SLIP, SLIPWAIT, DONE and FAIL.
REQ-016 IDLE, DONE and FAIL accept start_i, clear the status and eye registers, set tap=0 and go to LOAD; start_i is ignored in every other state.
REQ-017 LOAD drives delay_o=tap and load_o=1 for exactly one cycle, then enters SETTLE.
REQ-018 SETTLE counts SETTLE_CYCLES cycles, then enters CHECK.
REQ-019 CHECK captures the first word and compares CHECK_CYCLES consecutive words.
REQ-020 A tap is good when all CHECK_CYCLES words equal the first word and that word is one of the 4 rotations of TRAIN_PATTERN.
REQ-021 NEXT updates the current-run counters; a run's start and width are committed when width > best width (strictly greater, so the earliest eye wins a tie).
REQ-022 A run still open at tap 31 is evaluated before leaving NEXT; taps do not wrap.
REQ-023 NEXT increments tap and returns to LOAD while tap<31, otherwise enters CENTER.
REQ-024 CENTER goes to FAIL if best width < MIN_EYE.
REQ-025 Otherwise CENTER loads tap = eye_start + (eye_width>>1) with load_o pulsed, then enters CSETTLE for SETTLE_CYCLES cycles.
REQ-026 SLIPCHK goes to DONE if serdes_i == TRAIN_PATTERN.
REQ-027 Otherwise SLIPCHK enters SLIP if fewer than 4 slips have been issued, else FAIL.
REQ-028 SLIP pulses bitslip_o for one cycle, increments the slip count and enters SLIPWAIT; SLIPWAIT waits SLIP_WAIT cycles, then returns to SLIPCHK.
REQ-029 busy_o is 1 in every state except IDLE, DONE and FAIL.
REQ-030 delay_o holds its last loaded value outside load strobes.
REQ-031 load_o and bitslip_o are never asserted in the same cycle.
REQ-032 All outputs are registered.

Reset
REQ-033 rst_i, including mid-scan, forces IDLE on the next edge with delay_o=0, load_o=0, bitslip_o=0, busy_o=0, done_o=0, fail_o=0, eye_start_o=0, eye_width_o=0, and all counters cleared.
REQ-034 rst_i has priority over start_i.

Structure
REQ-035 Package ritc_align_pkg holds the state enumeration, tap width (5), eye-width width (6), and the maximum slip count (4).
REQ-036 One sub-module, ritc_align_pattern_match, holds the registered rotation-match and equal-to-first comparison.
REQ-037 The remainder of the block is a single FSM with its counters.

Verification
REQ-038 Good taps 10..20, TRAIN_PATTERN presented unrotated -> eye_start_o=10, eye_width_o=11, final delay_o=15, zero bitslips, done_o=1.
REQ-039 Good taps 2..4 and 20..24 -> eye_start_o=20, eye_width_o=5, delay_o=22.
REQ-040 Good taps 26..31 -> the run closes at tap 31, eye_start_o=26, eye_width_o=6, delay_o=29.
REQ-041 Eye at 5..9 with data rotated by 2 positions -> exactly 2 bitslip_o pulses separated by at least SLIP_WAIT+1 cycles, then done_o=1.
REQ-042 Only tap 7 good, or a rotation that never resolves after 4 slips -> fail_o=1, done_o=0.
REQ-043 Reset asserted during CHECK at tap 12 -> next cycle all outputs match REQ-033.
REQ-044 start_i asserted while busy_o=1 -> the scan is unaffected.
